// File: rtl/data_mem_pipe_pkg.sv
// rtl/data_mem_pipe_pkg.sv - width codes, response tag and lane/extension helpers for data_mem_pipe
package dmem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dmem_state_e;

  localparam logic [2:0] WIDTH_8S  = 3'b000;
  localparam logic [2:0] WIDTH_16S = 3'b001;
  localparam logic [2:0] WIDTH_32  = 3'b010;
  localparam logic [2:0] WIDTH_8U  = 3'b100;
  localparam logic [2:0] WIDTH_16U = 3'b101;

  // Travels alongside the RAM read so the tail knows how to shape the word.
  typedef struct packed {
    logic       valid;
    logic       err;
    logic       load;
    logic [2:0] width;
    logic [1:0] off;
  } rsp_tag_t;

  function automatic logic misaligned(input logic [2:0] width, input logic [1:0] off);
    case (width)
      WIDTH_32:             misaligned = (off != 2'b00);
      WIDTH_16S, WIDTH_16U: misaligned = off[0];
      WIDTH_8S, WIDTH_8U:   misaligned = 1'b0;
      default:              misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input logic [2:0] width, input logic [1:0] off);
    case (width)
      WIDTH_32:             be_gen = 4'b1111;
      WIDTH_16S, WIDTH_16U: be_gen = 4'b0011 << off;
      WIDTH_8S, WIDTH_8U:   be_gen = 4'b0001 << off;
      default:              be_gen = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] width,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (width)
      WIDTH_8S:  load_extend = {{24{b[7]}}, b};
      WIDTH_8U:  load_extend = {24'h000000, b};
      WIDTH_16S: load_extend = {{16{h[15]}}, h};
      WIDTH_16U: load_extend = {16'h0000, h};
      WIDTH_32:  load_extend = word;
      default:   load_extend = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_pipe_if.sv
// rtl/data_mem_pipe_if.sv - request/response bundle between the MEM pipeline register and data_mem_pipe
interface data_mem_pipe_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [2:0]            req_width_i;
  logic [DATA_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  flush_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_width_i, req_addr_i, req_wdata_i, flush_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_width_i, req_addr_i, req_wdata_i, flush_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/data_mem_ram.sv
// rtl/data_mem_ram.sv - 4-lane byte-write block RAM, registered read, optional output register
module data_mem_ram #(
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic [3:0]        we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  (* ram_style = "block" *) logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (we_i[k]) begin
        mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    if (re_i) begin
      rd_q <= mem[addr_i];
    end
  end

  if (READ_LATENCY == 2) begin : g_oreg
    logic [31:0] out_q;
    always_ff @(posedge clk_i) begin
      out_q <= rd_q;
    end
    assign rdata_o = out_q;
  end else begin : g_noreg
    assign rdata_o = rd_q;
  end

endmodule

// File: rtl/data_mem_pipe.sv
// rtl/data_mem_pipe.sv - MEM-stage data memory with fixed-latency in-order responses
// Define DMEM_ZERO_INIT_EN to zero-fill the RAM (CLEAR state) after every reset release.
module data_mem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input logic            clk_i,
  input logic            rst_n_i,
  data_mem_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  if (DATA_WIDTH != 32) begin : g_chk_width
    $error("data_mem_pipe: DATA_WIDTH must be 32");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("data_mem_pipe: DEPTH must be a power of 2 and >= 4");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_chk_lat
    $error("data_mem_pipe: READ_LATENCY must be 1 or 2");
  end

  dmem_state_e   state_q, state_d;
  logic          clearing;
  logic          clr_done;
  logic [AW-1:0] clr_idx;
  logic          flush_run;
  logic          accept;
  logic          req_err;
  logic [1:0]    req_off;
  logic [AW-1:0] req_idx;
  logic [3:0]    ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  rsp_tag_t      tag_in;
  rsp_tag_t      tail;
  rsp_tag_t      pipe_q [READ_LATENCY];
  logic          unused_addr;

`ifdef DMEM_ZERO_INIT_EN
  logic [AW-1:0] clr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clr_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  assign clearing = (state_q == CLEAR);
  assign clr_done = (clr_cnt_q == AW'(DEPTH - 1));
  assign clr_idx  = clr_cnt_q;
`else
  // Without zero-fill CLEAR only covers the first cycle after reset release.
  assign clearing = 1'b0;
  assign clr_done = 1'b1;
  assign clr_idx  = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_done) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign flush_run       = (state_q == RUN) & bus.flush_i;
  assign bus.req_ready_o = (state_q == RUN) & ~bus.flush_i;
  assign accept          = bus.req_valid_i & bus.req_ready_o;
  assign req_off         = bus.req_addr_i[1:0];
  assign req_idx         = bus.req_addr_i[AW+1:2];
  assign req_err         = misaligned(bus.req_width_i, req_off);
  assign unused_addr     = ^bus.req_addr_i[DATA_WIDTH-1:AW+2];

  always_comb begin
    ram_we   = 4'b0000;
    ram_re   = 1'b0;
    ram_addr = req_idx;
    case (bus.req_width_i)
      WIDTH_32:             ram_wdata = bus.req_wdata_i;
      WIDTH_16S, WIDTH_16U: ram_wdata = {2{bus.req_wdata_i[15:0]}};
      default:              ram_wdata = {4{bus.req_wdata_i[7:0]}};
    endcase
    if (clearing) begin
      ram_we    = 4'b1111;
      ram_addr  = clr_idx;
      ram_wdata = 32'h0;
    end else if (accept) begin
      // An errored store must not touch any lane.
      if (bus.req_we_i && !req_err) begin
        ram_we = be_gen(bus.req_width_i, req_off);
      end
      ram_re = ~bus.req_we_i;
    end
  end

  data_mem_ram #(
    .DEPTH       (DEPTH),
    .ADDR_W      (AW),
    .READ_LATENCY(READ_LATENCY)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept;
    tag_in.err   = req_err;
    tag_in.load  = ~bus.req_we_i;
    tag_in.width = bus.req_width_i;
    tag_in.off   = req_off;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (flush_run) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tail            = pipe_q[READ_LATENCY-1];
  assign bus.rsp_valid_o = tail.valid;
  assign bus.rsp_err_o   = tail.valid & tail.err;
  assign bus.rsp_rdata_o = (tail.valid && tail.load && !tail.err) ?
                           load_extend(ram_rdata, tail.width, tail.off) : 32'h0;

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb/tb_data_mem_pipe.sv - directed bench driving READ_LATENCY 1 and 2 instances in lockstep
module tb_data_mem_pipe;
  import dmem_pkg::*;

  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc1_q[$];
  int   acc2_q[$];
  rsp_t rsp1_q[$];
  rsp_t rsp2_q[$];
  int   drop1 = 0;
  int   drop2 = 0;
  int   spur1 = 0;
  int   spur2 = 0;
  int   n_rdy;

  data_mem_pipe_if #(.DATA_WIDTH(32)) if1 ();
  data_mem_pipe_if #(.DATA_WIDTH(32)) if2 ();

  data_mem_pipe #(.DATA_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if1)
  );
  data_mem_pipe #(.DATA_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Latency = response sample cycle minus the cycle in which the accept was seen.
  always @(negedge clk) begin
    rsp_t r;
    if (if1.req_valid_i && if1.req_ready_o) acc1_q.push_back(cyc);
    if (if1.rsp_valid_o) begin
      if (acc1_q.size() == 0) spur1++;
      else begin
        r.d = if1.rsp_rdata_o; r.e = if1.rsp_err_o; r.lat = cyc - acc1_q.pop_front();
        rsp1_q.push_back(r);
      end
    end
    if (if1.flush_i) begin
      drop1 += acc1_q.size();
      acc1_q.delete();
    end
  end

  always @(negedge clk) begin
    rsp_t r;
    if (if2.req_valid_i && if2.req_ready_o) acc2_q.push_back(cyc);
    if (if2.rsp_valid_o) begin
      if (acc2_q.size() == 0) spur2++;
      else begin
        r.d = if2.rsp_rdata_o; r.e = if2.rsp_err_o; r.lat = cyc - acc2_q.pop_front();
        rsp2_q.push_back(r);
      end
    end
    if (if2.flush_i) begin
      drop2 += acc2_q.size();
      acc2_q.delete();
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic f);
    if1.req_valid_i = v; if1.req_we_i = we; if1.req_width_i = w;
    if1.req_addr_i = a;  if1.req_wdata_i = d; if1.flush_i = f;
    if2.req_valid_i = v; if2.req_we_i = we; if2.req_width_i = w;
    if2.req_addr_i = a;  if2.req_wdata_i = d; if2.flush_i = f;
  endtask

  task automatic issue(input logic we, input logic [2:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    drive(1'b1, we, w, a, d, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, WIDTH_32, 32'h0, 32'h0, 1'b0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_to_ready(output int n);
    n = 0;
    while (!(if1.req_ready_o && if2.req_ready_o) && n < 4 * DEPTH) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] d, input logic e,
                            input bit on1, input bit on2);
    rsp_t r;
    if (on1) begin
      if (rsp1_q.size() == 0) check_eq({tag, " rl1 present"}, 32'd0, 32'd1);
      else begin
        r = rsp1_q.pop_front();
        check_eq({tag, " rl1 data"}, r.d, d);
        check_eq({tag, " rl1 err"}, {31'd0, r.e}, {31'd0, e});
        check_eq({tag, " rl1 latency"}, r.lat, 32'd1);
      end
    end
    if (on2) begin
      if (rsp2_q.size() == 0) check_eq({tag, " rl2 present"}, 32'd0, 32'd1);
      else begin
        r = rsp2_q.pop_front();
        check_eq({tag, " rl2 data"}, r.d, d);
        check_eq({tag, " rl2 err"}, {31'd0, r.e}, {31'd0, e});
        check_eq({tag, " rl2 latency"}, r.lat, 32'd2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, WIDTH_32, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst ready1", {31'd0, if1.req_ready_o}, 32'd0);
    check_eq("rst ready2", {31'd0, if2.req_ready_o}, 32'd0);
    check_eq("rst valid1", {31'd0, if1.rsp_valid_o}, 32'd0);
    check_eq("rst valid2", {31'd0, if2.rsp_valid_o}, 32'd0);
    check_eq("rst rdata1", if1.rsp_rdata_o, 32'd0);
    check_eq("rst rdata2", if2.rsp_rdata_o, 32'd0);
    check_eq("rst err1", {31'd0, if1.rsp_err_o}, 32'd0);
    check_eq("rst err2", {31'd0, if2.rsp_err_o}, 32'd0);
    rst_n = 1'b1;
    count_to_ready(n_rdy);
`ifdef DMEM_ZERO_INIT_EN
    check_eq("t6 clear cycles", n_rdy, DEPTH);
    // Reset in the middle of CLEAR must restart the fill from index 0.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6 ready in reset", {31'd0, if1.req_ready_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_to_ready(n_rdy);
    check_eq("t6 restart cycles", n_rdy, DEPTH);
    issue(1'b0, WIDTH_32, 32'h24, 32'h0);
    issue(1'b0, WIDTH_8S, 32'h3F, 32'h0);
    idle(4);
    expect_rsp("t6 zero w", 32'h0, 1'b0, 1, 1);
    expect_rsp("t6 zero b", 32'h0, 1'b0, 1, 1);
`else
    check_eq("ready after release", n_rdy, 32'd1);
`endif

    issue(1'b1, WIDTH_32,  32'h10, 32'hDEADBEEF);
    issue(1'b0, WIDTH_8S,  32'h13, 32'h0);
    issue(1'b0, WIDTH_8U,  32'h11, 32'h0);
    issue(1'b0, WIDTH_16S, 32'h12, 32'h0);
    issue(1'b0, WIDTH_16U, 32'h10, 32'h0);
    idle(4);
    expect_rsp("t1 store", 32'h0, 1'b0, 1, 1);
    expect_rsp("t1 8s", 32'hFFFFFFDE, 1'b0, 1, 1);
    expect_rsp("t1 8u", 32'h000000BE, 1'b0, 1, 1);
    expect_rsp("t1 16s", 32'hFFFFDEAD, 1'b0, 1, 1);
    expect_rsp("t1 16u", 32'h0000BEEF, 1'b0, 1, 1);

    issue(1'b1, WIDTH_32,  32'h20, 32'h11223344);
    issue(1'b1, WIDTH_8S,  32'h21, 32'hABCDEF7A);
    issue(1'b0, WIDTH_32,  32'h20, 32'h0);
    issue(1'b1, WIDTH_16S, 32'h22, 32'h99995566);
    issue(1'b0, WIDTH_32,  32'h20, 32'h0);
    issue(1'b0, WIDTH_8U,  32'h23, 32'h0);
    idle(4);
    expect_rsp("t2 st w", 32'h0, 1'b0, 1, 1);
    expect_rsp("t2 st b", 32'h0, 1'b0, 1, 1);
    expect_rsp("t2 ld b2b", 32'h11227A44, 1'b0, 1, 1);
    expect_rsp("t2 st h", 32'h0, 1'b0, 1, 1);
    expect_rsp("t2 ld h", 32'h55667A44, 1'b0, 1, 1);
    expect_rsp("t2 ld 8u", 32'h00000055, 1'b0, 1, 1);

    issue(1'b1, WIDTH_32,  32'h14, 32'hCAFEF00D);
    issue(1'b0, WIDTH_32,  32'h16, 32'h0);
    issue(1'b1, WIDTH_16S, 32'h13, 32'h0000FFFF);
    issue(1'b0, 3'b111,    32'h14, 32'h0);
    issue(1'b1, 3'b111,    32'h14, 32'h12345678);
    issue(1'b0, WIDTH_32,  32'h14, 32'h0);
    issue(1'b0, WIDTH_32,  32'h10, 32'h0);
    idle(4);
    expect_rsp("t3 st w", 32'h0, 1'b0, 1, 1);
    expect_rsp("t3 ld misal", 32'h0, 1'b1, 1, 1);
    expect_rsp("t3 st misal", 32'h0, 1'b1, 1, 1);
    expect_rsp("t3 ld bad", 32'h0, 1'b1, 1, 1);
    expect_rsp("t3 st bad", 32'h0, 1'b1, 1, 1);
    expect_rsp("t3 reread14", 32'hCAFEF00D, 1'b0, 1, 1);
    expect_rsp("t3 reread10", 32'hDEADBEEF, 1'b0, 1, 1);

    issue(1'b0, WIDTH_32, 32'h10, 32'h0);
    issue(1'b0, WIDTH_32, 32'h14, 32'h0);
    drive(1'b1, 1'b0, WIDTH_32, 32'h20, 32'h0, 1'b1);
    #1;
    check_eq("t4 ready1 flush", {31'd0, if1.req_ready_o}, 32'd0);
    check_eq("t4 ready2 flush", {31'd0, if2.req_ready_o}, 32'd0);
    @(posedge clk); #1;
    idle(4);
    expect_rsp("t4 a", 32'hDEADBEEF, 1'b0, 1, 1);
    expect_rsp("t4 b", 32'hCAFEF00D, 1'b0, 1, 0);
    check_eq("t4 killed rl1", drop1, 32'd0);
    check_eq("t4 killed rl2", drop2, 32'd1);
    issue(1'b0, WIDTH_32, 32'h20, 32'h0);
    issue(1'b0, WIDTH_32, 32'h14, 32'h0);
    idle(4);
    expect_rsp("t4 c", 32'h55667A44, 1'b0, 1, 1);
    expect_rsp("t4 d", 32'hCAFEF00D, 1'b0, 1, 1);

    issue(1'b1, WIDTH_32, 32'h10 + DEPTH * 4, 32'h0BADF00D);
    idle(2);
    issue(1'b0, WIDTH_32, 32'h10, 32'h0);
    idle(3);
    issue(1'b0, WIDTH_32, 32'h10 + DEPTH * 8, 32'h0);
    idle(4);
    expect_rsp("t5 st alias", 32'h0, 1'b0, 1, 1);
    expect_rsp("t5 ld base", 32'h0BADF00D, 1'b0, 1, 1);
    expect_rsp("t5 ld alias2", 32'h0BADF00D, 1'b0, 1, 1);

    check_eq("spurious rl1", spur1, 32'd0);
    check_eq("spurious rl2", spur2, 32'd0);
    check_eq("leftover rl1", rsp1_q.size() + acc1_q.size(), 32'd0);
    check_eq("leftover rl2", rsp2_q.size() + acc2_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
